// File: rtl/search_rr_arbiter.sv
// search_rr_arbiter
//   Round-robin collector for the pixel-core array. Scans NB core done flags
//   from a rotating pointer. It captures the winning core's address and pixel
//   into a registered output stage and pulses a one-hot ack (mask) to release
//   that core. The result then goes to the frame writer over a valid/ready
//   handshake.
//
// Parameters
//   NB  number of pixel cores (>=1)
//   AW  per-core pixel address width
//   DW  per-core pixel data width
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   search_en     1 = new captures allowed, 0 = pause (held result still drains)
//   cataddresses  core i address at [i*AW +: AW]
//   catpixels     core i pixel at [i*DW +: DW]
//   done          per-core result-pending flags
//   mask          one-hot, one-cycle ack to the captured core
//   found         one-cycle pulse, high exactly when mask != 0
//   out_valid     output stage holds a result
//   out_ready     writer accepts the held result this cycle
//   sel_address   captured address, stable while out_valid
//   sel_data      captured pixel, stable while out_valid
//   result_count  accepted-result counter (present only with SEARCH_CNT_EN)
//
// Configuration macro: SEARCH_CNT_EN adds the 32-bit wrapping result_count.

module search_rr_arbiter #(
  parameter int NB = 4,
  parameter int AW = 32,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             search_en,
  input  logic [NB*AW-1:0] cataddresses,
  input  logic [NB*DW-1:0] catpixels,
  input  logic [NB-1:0]    done,
  output logic [NB-1:0]    mask,
  output logic             found,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    sel_address,
  output logic [DW-1:0]    sel_data
`ifdef SEARCH_CNT_EN
  ,
  output logic [31:0]      result_count
`endif
);

  localparam int PW = (NB > 1) ? $clog2(NB) : 1;

  logic [NB-1:0] mask_q, mask_d;
  logic          found_q, found_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic [NB-1:0] cand;
  logic [PW-1:0] win;
  logic          hit_hi, hit_lo, hit;
  logic [PW-1:0] win_hi, win_lo;
  logic          capture;

  // The core acked last cycle may still show done; exclude it.
  assign cand = done & ~mask_q;

  // Rotating priority as two fixed-priority passes: lowest candidate at or
  // above ptr wins; otherwise wrap to the lowest candidate overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (cand[i]) begin
        hit_lo = 1'b1;
        win_lo = PW'(i);
        if (i >= int'(ptr_q)) begin
          hit_hi = 1'b1;
          win_hi = PW'(i);
        end
      end
    end
    hit = hit_hi | hit_lo;
    win = hit_hi ? win_hi : win_lo;
  end

  // A new result may enter when the stage is empty or being drained now.
  assign capture = search_en && hit && (!vld_q || out_ready);

  always_comb begin
    mask_d  = '0;
    found_d = 1'b0;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = out_ready ? 1'b0 : vld_q;
    if (capture) begin
      mask_d  = NB'(1) << win;
      found_d = 1'b1;
      vld_d   = 1'b1;
      ptr_d   = (int'(win) == NB - 1) ? '0 : win + PW'(1);
      for (int i = 0; i < NB; i++) begin
        if (PW'(i) == win) begin
          addr_d = cataddresses[i*AW +: AW];
          data_d = catpixels[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q  <= '0;
      found_q <= 1'b0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      mask_q  <= mask_d;
      found_q <= found_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign mask        = mask_q;
  assign found       = found_q;
  assign out_valid   = vld_q;
  assign sel_address = addr_q;
  assign sel_data    = data_q;

`ifdef SEARCH_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (vld_q && out_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign result_count = cnt_q;
`endif

endmodule
